// File: rtl/pdm_decimator.sv
// PDM microphone decimator: 2nd-order CIC filter with decimation by DECIM,
// conversion of the unsigned CIC result to signed PCM, a warm-up discard of
// the first two results, and a single-entry output register with a
// valid/ready handshake and a sticky overrun flag.
module pdm_decimator #(
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16,
    parameter int CHANNEL = 0
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pdm_in,
    output logic             mic_lr_sel,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun,
    input  logic             clear_ovr
);

    localparam int L     = $clog2(DECIM);
    localparam int W     = 2 * L + 1;
    localparam int SHIFT = OUT_W - W;

    localparam logic [L-1:0] LAST_PHASE = L'(DECIM - 1);
    localparam logic [W-1:0] MIDSCALE   = W'(DECIM * DECIM / 2);
    localparam logic [1:0]   WARM_DONE  = 2'd2;

    logic [L-1:0] phase;
    logic [W-1:0] integ1;
    logic [W-1:0] integ2;
    logic [W-1:0] comb1_dly;
    logic [W-1:0] comb2_dly;
    logic [1:0]   warm;

    logic [W-1:0] integ1_next;
    logic [W-1:0] integ2_next;
    logic [W-1:0] comb1;
    logic [W-1:0] comb2;
    logic         decim_edge;
    logic         publish;
    logic         transfer;

    logic signed [W-1:0]     offset_s;
    logic signed [OUT_W-1:0] offset_ext;
    logic [OUT_W-1:0]        pcm_next;

    assign mic_lr_sel = (CHANNEL != 0);

    // Integrator values including this edge's sample, so the comb sees the
    // full window on the decimation edge itself.
    assign integ1_next = integ1 + W'(pdm_in);
    assign integ2_next = integ2 + integ1_next;
    assign comb1       = integ2_next - comb1_dly;
    assign comb2       = comb1 - comb2_dly;

    assign decim_edge = enable && (phase == LAST_PHASE);
    assign publish    = decim_edge && (warm == WARM_DONE);
    assign transfer   = pcm_valid && pcm_ready;

    // Recentre the 0..DECIM^2 CIC result around zero, sign-extend, then
    // scale up to the full PCM width.
    assign offset_s   = signed'(comb2 - MIDSCALE);
    assign offset_ext = OUT_W'(offset_s);
    assign pcm_next   = offset_ext <<< SHIFT;

    // CIC datapath, phase and warm-up; disabling clears the partial window.
    always_ff @(posedge mclk) begin
        if (reset || !enable) begin
            phase     <= '0;
            integ1    <= '0;
            integ2    <= '0;
            comb1_dly <= '0;
            comb2_dly <= '0;
            warm      <= '0;
        end else begin
            phase  <= phase + L'(1);
            integ1 <= integ1_next;
            integ2 <= integ2_next;
            if (decim_edge) begin
                comb1_dly <= integ2_next;
                comb2_dly <= comb1;
                if (warm != WARM_DONE) begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

    // Output register: a publish always wins, otherwise a transfer empties it.
    always_ff @(posedge mclk) begin
        if (reset) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
        end else if (publish) begin
            pcm_data  <= pcm_next;
            pcm_valid <= 1'b1;
        end else if (transfer) begin
            pcm_valid <= 1'b0;
        end
    end

    // Sticky overrun: an unconsumed sample being overwritten beats a clear.
    always_ff @(posedge mclk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (publish && pcm_valid && !pcm_ready) begin
            overrun <= 1'b1;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule
